reg_file_sb: RTL and testbench

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/reg_file_sb_pkg.sv | 10 +
 rtl/reg_file_sb_rdport.sv | 26 ++
 rtl/reg_file_sb.sv | 64 ++++++
 tb/tb_reg_file_sb.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/reg_file_sb_pkg.sv
// reg_file_sb_pkg: shared FSM states, parameter defaults and address-width helper
package reg_file_sb_pkg;
    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;
    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int NRD_DEF   = 2;
    function automatic int addr_width(input int n);
        return $clog2(n);
    endfunction
endpackage

// File: rtl/reg_file_sb_rdport.sv
// reg_file_sb_rdport: one combinational read port with zero-address rule, write bypass and busy flag
module reg_file_sb_rdport
    import reg_file_sb_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    localparam int AW   = addr_width(NREGS)
)(
    input  logic            run,
    input  logic [XLEN-1:0] regs [NREGS],
    input  logic [NREGS-1:0] busy,
    input  logic            w_en,
    input  logic [AW-1:0]   w_addr,
    input  logic [XLEN-1:0] w_data,
    input  logic [AW-1:0]   r_addr,
    output logic [XLEN-1:0] r_data,
    output logic            r_busy
);
    logic hit;
    logic nz;
    assign nz  = r_addr != '0;
    assign hit = w_en && w_addr == r_addr;
    // a same-cycle write supplies the data, so that port is never reported busy
    assign r_data = !(run && nz) ? '0 : hit ? w_data : regs[r_addr];
    assign r_busy = run && nz && busy[r_addr] && !hit;
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with power-up clear sweep, multi-port bypassed reads and a busy scoreboard
module reg_file_sb
    import reg_file_sb_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = NRD_DEF,
    localparam int AW   = addr_width(NREGS)
)(
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                W_EN,
    input  logic [AW-1:0]       W_ADDR,
    input  logic [XLEN-1:0]     W_DATA,
    input  logic [NRD*AW-1:0]   R_ADDR,
    output logic [NRD*XLEN-1:0] R_DATA,
    output logic [NRD-1:0]      R_BUSY,
    input  logic                SB_SET,
    input  logic [AW-1:0]       SB_ADDR,
    output logic                READY
);
    state_t          state;
    logic [AW-1:0]   ptr;
    logic [XLEN-1:0] regs [NREGS];
    logic [NREGS-1:0] busy;
    logic            run;

    assign run   = state == ST_RUN;
    assign READY = run;

    // contents survive reset; only the sweep zeroes them
    always_ff @(posedge CLK) begin
        if (RST_N && !run) regs[ptr] <= '0;
        else if (RST_N && W_EN && W_ADDR != '0) regs[W_ADDR] <= W_DATA;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= ST_INIT;
            ptr   <= AW'(1);
            busy  <= '0;
        end else if (!run) begin
            ptr <= ptr + AW'(1);
            if (ptr == AW'(NREGS - 1)) state <= ST_RUN;
        end else begin
            if (W_EN) busy[W_ADDR] <= 1'b0;
            if (SB_SET && SB_ADDR != '0) busy[SB_ADDR] <= 1'b1;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        reg_file_sb_rdport #(.XLEN(XLEN), .NREGS(NREGS)) u_rd (
            .run    (run),
            .regs   (regs),
            .busy   (busy),
            .w_en   (W_EN),
            .w_addr (W_ADDR),
            .w_data (W_DATA),
            .r_addr (R_ADDR[k*AW +: AW]),
            .r_data (R_DATA[k*XLEN +: XLEN]),
            .r_busy (R_BUSY[k])
        );
    end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed self-checking bench for reg_file_sb with default parameters
module tb_reg_file_sb;
    localparam int XLEN = 32;
    localparam int NRD  = 2;
    localparam int AW   = 5;

    logic            CLK = 1'b0;
    logic            RST_N;
    logic            W_EN;
    logic [AW-1:0]   W_ADDR;
    logic [XLEN-1:0] W_DATA;
    logic [NRD*AW-1:0]   R_ADDR;
    logic [NRD*XLEN-1:0] R_DATA;
    logic [NRD-1:0]  R_BUSY;
    logic            SB_SET;
    logic [AW-1:0]   SB_ADDR;
    logic            READY;
    int n_tests = 0;
    int n_fail  = 0;

    reg_file_sb dut (
        .CLK(CLK), .RST_N(RST_N), .W_EN(W_EN), .W_ADDR(W_ADDR), .W_DATA(W_DATA),
        .R_ADDR(R_ADDR), .R_DATA(R_DATA), .R_BUSY(R_BUSY),
        .SB_SET(SB_SET), .SB_ADDR(SB_ADDR), .READY(READY)
    );

    always #5 CLK = ~CLK;

    function automatic logic [XLEN-1:0] rd(input int k);
        return R_DATA[k*XLEN +: XLEN];
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_rd(input int k, input logic [AW-1:0] a);
        R_ADDR[k*AW +: AW] = a;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        tick();
        n_tests++;
        if (READY !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", READY); end
        RST_N = 1'b1;
        W_EN = 1'b1; W_ADDR = 5'd2; W_DATA = 32'hCAFE0002;
        SB_SET = 1'b1; SB_ADDR = 5'd4;
        set_rd(0, 5'd2); set_rd(1, 5'd4);
        for (int i = 1; i <= 31; i++) begin
            tick();
            n_tests++;
            if (READY !== (i == 31)) begin n_fail++; $display("FAIL sweep_ready edge %0d: got %b want %b", i, READY, i == 31); end
            if (i < 31) begin
                n_tests++;
                if (rd(0) !== 32'h0 || R_BUSY !== 2'b00) begin
                    n_fail++; $display("FAIL init_read edge %0d: got %h/%b want 0/00", i, rd(0), R_BUSY);
                end
            end
        end
        W_EN = 1'b0; SB_SET = 1'b0;
        for (int a = 0; a < 32; a++) begin
            set_rd(0, 5'(a)); set_rd(1, 5'(31 - a));
            #1;
            n_tests++;
            if (rd(0) !== 32'h0 || rd(1) !== 32'h0 || R_BUSY !== 2'b00) begin
                n_fail++; $display("FAIL post_sweep addr %0d: got %h %h busy %b want 0 0 00", a, rd(0), rd(1), R_BUSY);
            end
        end
    endtask

    task automatic test_bypass();
        W_EN = 1'b1; W_ADDR = 5'd5; W_DATA = 32'hDEADBEEF; set_rd(0, 5'd5);
        #1;
        n_tests++;
        if (rd(0) !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bypass: got %h want deadbeef", rd(0)); end
        tick();
        W_EN = 1'b0;
        #1;
        n_tests++;
        if (rd(0) !== 32'hDEADBEEF) begin n_fail++; $display("FAIL stored: got %h want deadbeef", rd(0)); end
        tick();
        n_tests++;
        if (rd(0) !== 32'hDEADBEEF) begin n_fail++; $display("FAIL stored_later: got %h want deadbeef", rd(0)); end
    endtask

    task automatic test_zero();
        W_EN = 1'b1; W_ADDR = 5'd0; W_DATA = 32'h12345678; set_rd(0, 5'd0);
        #1;
        n_tests++;
        if (rd(0) !== 32'h0) begin n_fail++; $display("FAIL zero_bypass: got %h want 0", rd(0)); end
        tick();
        W_EN = 1'b0;
        #1;
        n_tests++;
        if (rd(0) !== 32'h0 || R_BUSY[0] !== 1'b0) begin n_fail++; $display("FAIL zero_read: got %h/%b want 0/0", rd(0), R_BUSY[0]); end
    endtask

    task automatic test_scoreboard();
        SB_SET = 1'b1; SB_ADDR = 5'd7; set_rd(1, 5'd7); set_rd(0, 5'd7);
        #1;
        n_tests++;
        if (R_BUSY !== 2'b00) begin n_fail++; $display("FAIL sb_before: got %b want 00", R_BUSY); end
        tick();
        SB_SET = 1'b0;
        #1;
        n_tests++;
        if (R_BUSY !== 2'b11) begin n_fail++; $display("FAIL sb_set: got %b want 11", R_BUSY); end
        W_EN = 1'b1; W_ADDR = 5'd7; W_DATA = 32'hA5;
        #1;
        n_tests++;
        if (R_BUSY[1] !== 1'b0 || rd(1) !== 32'hA5) begin n_fail++; $display("FAIL sb_bypass: got %b/%h want 0/a5", R_BUSY[1], rd(1)); end
        tick();
        W_EN = 1'b0;
        #1;
        n_tests++;
        if (R_BUSY !== 2'b00 || rd(1) !== 32'hA5 || rd(0) !== 32'hA5) begin
            n_fail++; $display("FAIL sb_cleared: got %b/%h/%h want 00/a5/a5", R_BUSY, rd(1), rd(0));
        end
    endtask

    task automatic test_set_wins();
        SB_SET = 1'b1; SB_ADDR = 5'd9; W_EN = 1'b1; W_ADDR = 5'd9; W_DATA = 32'h99; set_rd(1, 5'd9);
        #1;
        n_tests++;
        if (R_BUSY[1] !== 1'b0 || rd(1) !== 32'h99) begin n_fail++; $display("FAIL setwin_bypass: got %b/%h want 0/99", R_BUSY[1], rd(1)); end
        tick();
        SB_SET = 1'b0; W_EN = 1'b0;
        #1;
        n_tests++;
        if (R_BUSY[1] !== 1'b1 || rd(1) !== 32'h99) begin n_fail++; $display("FAIL setwin_after: got %b/%h want 1/99", R_BUSY[1], rd(1)); end
    endtask

    task automatic test_ports();
        W_EN = 1'b1; W_ADDR = 5'd12; W_DATA = 32'h1111;
        tick();
        W_ADDR = 5'd13; W_DATA = 32'h2222;
        tick();
        W_EN = 1'b0; set_rd(0, 5'd12); set_rd(1, 5'd13);
        #1;
        n_tests++;
        if (rd(0) !== 32'h1111 || rd(1) !== 32'h2222) begin n_fail++; $display("FAIL ports: got %h %h want 1111 2222", rd(0), rd(1)); end
    endtask

    task automatic test_reset_mid_run();
        W_EN = 1'b1; W_ADDR = 5'd3; W_DATA = 32'h55;
        SB_SET = 1'b1; SB_ADDR = 5'd11;
        tick();
        W_EN = 1'b0; SB_SET = 1'b0; set_rd(0, 5'd3); set_rd(1, 5'd11);
        #1;
        n_tests++;
        if (rd(0) !== 32'h55 || R_BUSY[1] !== 1'b1) begin n_fail++; $display("FAIL pre_reset: got %h/%b want 55/1", rd(0), R_BUSY[1]); end
        RST_N = 1'b0; W_EN = 1'b1; W_DATA = 32'h77; SB_SET = 1'b1; SB_ADDR = 5'd3;
        tick();
        n_tests++;
        if (READY !== 1'b0 || rd(0) !== 32'h0) begin n_fail++; $display("FAIL mid_reset: got %b/%h want 0/0", READY, rd(0)); end
        RST_N = 1'b1;
        for (int i = 1; i <= 31; i++) tick();
        n_tests++;
        if (READY !== 1'b1) begin n_fail++; $display("FAIL resweep_ready: got %b want 1", READY); end
        W_EN = 1'b0; SB_SET = 1'b0;
        #1;
        n_tests++;
        if (rd(0) !== 32'h0) begin n_fail++; $display("FAIL resweep_reg3: got %h want 0", rd(0)); end
        for (int a = 1; a < 32; a++) begin
            set_rd(0, 5'(a)); set_rd(1, 5'(a));
            #1;
            n_tests++;
            if (R_BUSY !== 2'b00 || rd(0) !== rd(1)) begin n_fail++; $display("FAIL resweep_busy addr %0d: got %b want 00", a, R_BUSY); end
        end
        set_rd(0, 5'd12);
        #1;
        n_tests++;
        if (rd(0) !== 32'h0) begin n_fail++; $display("FAIL resweep_reg12: got %h want 0", rd(0)); end
    endtask

    initial begin
        RST_N = 1'b0; W_EN = 1'b0; W_ADDR = '0; W_DATA = '0;
        R_ADDR = '0; SB_SET = 1'b0; SB_ADDR = '0;
        test_reset();
        test_bypass();
        test_zero();
        test_scoreboard();
        test_set_wins();
        test_ports();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
